hba_gpio_irq: RTL
=================

Name: hba_gpio_irq

Overview:
- Parametrised successor to the 4-bit HBA GPIO slave, used when an HBA peripheral slot needs a GPIO port with interrupts.
- Provides GPIO_WIDTH bidirectional pins with a per-pin direction register and an output register.
- Inputs pass through synchronisers, then per-pin rising/falling edge detection into sticky, write-1-to-clear interrupt status.
- Sits behind the serial master on the HBA bus; pins reach the package through SB_IO tri-state cells instantiated at top level.

Parameters:
- DBUS_WIDTH, 8, HBA data bus width.
- REG_ADDR_WIDTH, 8, HBA register address width.
- GPIO_WIDTH, 8, number of pins; 1..DBUS_WIDTH.
- DEBOUNCE_CYCLES, 16, stable-cycle count for the optional debounce; minimum 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- hba_select  in  1  slave selected; held by the master until hba_xferack.
- hba_rnw  in  1  1 = read, 0 = write.
- hba_abus  in  REG_ADDR_WIDTH  register address.
- hba_dbus  in  DBUS_WIDTH  write data.
- hba_dbus_slave  out  DBUS_WIDTH  read data; zero when not acking (bus is OR-combined).
- hba_xferack_slave  out  1  one-cycle transfer acknowledge.
- hba_interrupt_slave  out  1  level interrupt.
- gpio_out_en  out  GPIO_WIDTH  1 = drive pin.
- gpio_out_sig  out  GPIO_WIDTH  output value.
- gpio_in_sig  in  GPIO_WIDTH  raw pin value (asynchronous).

Behaviour:
- Reset is asynchronous, active-low. On reset every register and every output is 0: all pins are inputs, no ack, no interrupt.
- Register map. Upper DBUS_WIDTH-GPIO_WIDTH bits read 0 and are ignored on write.
  - 0 DIR: RW, 1 = output, drives gpio_out_en.
  - 1 OUT: RW, drives gpio_out_sig.
  - 2 IN: RO, filtered input.
  - 3 RISE_EN: RW.
  - 4 FALL_EN: RW.
  - 5 INT_STAT: read returns status; write is W1C.
  - 6 INT_EN: RW, bit 0 = global interrupt enable.
  - Other addresses: reads return 0, writes are ignored, the transfer is still acked.
- Bus FSM has two states, IDLE and ACK.
  - IDLE -> ACK when hba_select=1. The write takes effect, or read data is registered, in that same edge.
  - In ACK: hba_xferack_slave=1 for exactly one cycle; hba_dbus_slave carries the read data (0 on writes). Then ACK -> IDLE unconditionally.
  - Select still high in the IDLE cycle after ACK starts a new transfer, so back-to-back transfers are acked at most every 2 cycles.
  - Inputs are sampled only on the IDLE->ACK edge. Changes to abus/dbus while in ACK are ignored.
  - Reset asserted mid-transfer drops the ack immediately; the FSM returns to IDLE.
- Input path: 2-flop synchroniser -> filter -> prev register. IN reflects a pin change 2 cycles after it (plus debounce time if enabled).
- Edge detection:
  - rise = filt & ~prev & RISE_EN; fall = ~filt & prev & FALL_EN.
  - An event sets the matching INT_STAT bit on the next edge.
  - A prime flag suppresses edges until 3 cycles after reset release, so a pulled-up pin does not give a false rise.
  - Pins configured as outputs still detect edges (read-back loop).
- Simultaneous edge event and W1C on the same bit: the set wins, and the bit stays 1.
- hba_interrupt_slave = registered (|INT_STAT & INT_EN[0]); it asserts 1 cycle after the status bit sets.
- Writing DIR/OUT updates gpio_out_en/gpio_out_sig on the cycle the ack is asserted.

Optional Feature:
- Macro: HBA_GPIO_IRQ_DEBOUNCE_EN.
- Defined: per-pin counter of width $clog2(DEBOUNCE_CYCLES).
  - filt[i] takes synced[i] only after synced[i] has differed from filt[i] for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to filt[i] clears the counter.
  - Counters and filt reset to 0.
- Undefined: filt = synced; no counters are synthesised.

Decomposition:
- Shared package hba_gpio_irq_pkg holds:
  - register address constants (REG_DIR..REG_INT_EN);
  - the bus FSM state encoding;
  - the default DEBOUNCE_CYCLES.
- One natural sub-module: gpio_in_filter, one instance per pin, containing the synchroniser, the optional debounce and the prev/edge outputs.

Test Plan:
- Reset with gpio_in_sig=8'hFF, then release reset_n → gpio_out_en=0, INT_STAT reads 0, no interrupt within 10 cycles.
- Write DIR=8'h0F, OUT=8'hA5 → gpio_out_en=8'h0F, gpio_out_sig=8'hA5. Each write acked for 1 cycle, 1 cycle after select. Reads of 0/1 return 8'h0F/8'hA5; read of address 9 returns 0 and is acked.
- RISE_EN=8'h01, INT_EN=1, drive pin0 0→1 → INT_STAT=8'h01 and interrupt high. Read IN shows bit0=1. Write INT_STAT=8'h01 → interrupt drops 1 cycle later.
- FALL_EN=8'h80, pulse pin7 1→0 on the same edge that a W1C of 8'h80 is captured → INT_STAT bit7 remains 1.
- Back-to-back selects held high for 6 cycles → exactly 3 ack pulses, on alternate cycles. Assert reset_n low during ACK → ack drops asynchronously.
- With HBA_GPIO_IRQ_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle glitch on pin2 → IN bit2 unchanged and no interrupt. A 20-cycle level → IN bit2 updates 16 cycles after the synchroniser output changes.

Source files
------------

// File: rtl/hba_gpio_irq_pkg.sv
// Shared constants for the HBA GPIO slave with edge interrupts: register map,
// bus FSM encoding and the default debounce length.
package hba_gpio_irq_pkg;

    localparam int unsigned REG_DIR      = 0;
    localparam int unsigned REG_OUT      = 1;
    localparam int unsigned REG_IN       = 2;
    localparam int unsigned REG_RISE_EN  = 3;
    localparam int unsigned REG_FALL_EN  = 4;
    localparam int unsigned REG_INT_STAT = 5;
    localparam int unsigned REG_INT_EN   = 6;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/gpio_in_filter.sv
// Per-pin input conditioning: 2-flop synchroniser, optional debounce
// (HBA_GPIO_IRQ_DEBOUNCE_EN), previous-value register and raw edge flags.
module gpio_in_filter
    import hba_gpio_irq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic filt,
    output logic rise_c,
    output logic fall_c
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    if (DEBOUNCE_CYCLES < 2) begin : g_cfg_err
        $error("gpio_in_filter: DEBOUNCE_CYCLES must be at least 2");
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
        end
    end

`ifdef HBA_GPIO_IRQ_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;

    // filt follows sync only after DEBOUNCE_CYCLES consecutive differing cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync2_q == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q  <= '0;
            filt_q <= sync2_q;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= filt;
        end
    end

    assign rise_c = filt & ~prev_q;
    assign fall_c = ~filt & prev_q;

endmodule

// File: rtl/hba_gpio_irq.sv
// HBA bus GPIO slave: direction/output registers, filtered inputs and sticky
// W1C edge interrupts. Optional debounce via HBA_GPIO_IRQ_DEBOUNCE_EN.
module hba_gpio_irq
    import hba_gpio_irq_pkg::*;
#(
    parameter int unsigned DBUS_WIDTH      = 8,
    parameter int unsigned REG_ADDR_WIDTH  = 8,
    parameter int unsigned GPIO_WIDTH      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      hba_select,
    input  logic                      hba_rnw,
    input  logic [REG_ADDR_WIDTH-1:0] hba_abus,
    input  logic [DBUS_WIDTH-1:0]     hba_dbus,
    output logic [DBUS_WIDTH-1:0]     hba_dbus_slave,
    output logic                      hba_xferack_slave,
    output logic                      hba_interrupt_slave,
    output logic [GPIO_WIDTH-1:0]     gpio_out_en,
    output logic [GPIO_WIDTH-1:0]     gpio_out_sig,
    input  logic [GPIO_WIDTH-1:0]     gpio_in_sig
);

    if (GPIO_WIDTH < 1 || GPIO_WIDTH > DBUS_WIDTH) begin : g_cfg_err
        $error("hba_gpio_irq: GPIO_WIDTH must be in 1..DBUS_WIDTH");
    end

    logic [0:0]            state_q;
    logic [0:0]            state_nxt;
    logic                  accept_c;
    logic [GPIO_WIDTH-1:0] dir_q, out_q, rise_en_q, fall_en_q, int_stat_q, int_en_q;
    logic [DBUS_WIDTH-1:0] rdata_q, rd_mux_c;
    logic [GPIO_WIDTH-1:0] wdata_c, w1c_c, events_c;
    logic [GPIO_WIDTH-1:0] filt, rise_c, fall_c;
    logic                  irq_q;
    logic [1:0]            prime_q;
    logic                  primed_c;

    for (genvar i = 0; i < int'(GPIO_WIDTH); i++) begin : g_pin
        gpio_in_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_filter (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (gpio_in_sig[i]),
            .filt   (filt[i]),
            .rise_c (rise_c[i]),
            .fall_c (fall_c[i])
        );
    end

    // Bus FSM: one ACK cycle per accepted transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        accept_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hba_select) begin
                    state_nxt = ST_ACK;
                    accept_c  = 1'b1;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux_c = '0;
        case (hba_abus)
            REG_ADDR_WIDTH'(REG_DIR):      rd_mux_c = DBUS_WIDTH'(dir_q);
            REG_ADDR_WIDTH'(REG_OUT):      rd_mux_c = DBUS_WIDTH'(out_q);
            REG_ADDR_WIDTH'(REG_IN):       rd_mux_c = DBUS_WIDTH'(filt);
            REG_ADDR_WIDTH'(REG_RISE_EN):  rd_mux_c = DBUS_WIDTH'(rise_en_q);
            REG_ADDR_WIDTH'(REG_FALL_EN):  rd_mux_c = DBUS_WIDTH'(fall_en_q);
            REG_ADDR_WIDTH'(REG_INT_STAT): rd_mux_c = DBUS_WIDTH'(int_stat_q);
            REG_ADDR_WIDTH'(REG_INT_EN):   rd_mux_c = DBUS_WIDTH'(int_en_q);
            default:                       rd_mux_c = '0;
        endcase
    end

    assign wdata_c  = hba_dbus[GPIO_WIDTH-1:0];
    assign w1c_c    = (accept_c && !hba_rnw && hba_abus == REG_ADDR_WIDTH'(REG_INT_STAT))
                      ? wdata_c : '0;
    assign primed_c = (prime_q == 2'd3);
    // Edge events win over a same-cycle W1C because they are OR-ed in last
    assign events_c = primed_c ? ((rise_c & rise_en_q) | (fall_c & fall_en_q)) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q      <= '0;
            out_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            int_stat_q <= '0;
            int_en_q   <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            prime_q    <= 2'd0;
        end else begin
            rdata_q <= '0;
            if (accept_c && hba_rnw) begin
                rdata_q <= rd_mux_c;
            end
            if (accept_c && !hba_rnw) begin
                case (hba_abus)
                    REG_ADDR_WIDTH'(REG_DIR):     dir_q     <= wdata_c;
                    REG_ADDR_WIDTH'(REG_OUT):     out_q     <= wdata_c;
                    REG_ADDR_WIDTH'(REG_RISE_EN): rise_en_q <= wdata_c;
                    REG_ADDR_WIDTH'(REG_FALL_EN): fall_en_q <= wdata_c;
                    REG_ADDR_WIDTH'(REG_INT_EN):  int_en_q  <= wdata_c;
                    default: ;
                endcase
            end
            int_stat_q <= (int_stat_q & ~w1c_c) | events_c;
            irq_q      <= (|int_stat_q) & int_en_q[0];
            if (!primed_c) begin
                prime_q <= prime_q + 2'd1;
            end
        end
    end

    assign hba_xferack_slave   = (state_q == ST_ACK);
    assign hba_dbus_slave      = rdata_q;
    assign hba_interrupt_slave = irq_q;
    assign gpio_out_en         = dir_q;
    assign gpio_out_sig        = out_q;

endmodule
